// File: rtl/linebuf_wrctrl.sv
// Write-side line buffer controller: strips leading pixels, writes each active line
// into round-robin RAM pages and reports page/length/overflow when a line closes.
module linebuf_wrctrl #(
   parameter int unsigned num_of_pages = 4,
   parameter int unsigned pagesize     = 1024,
   parameter int unsigned data_width   = 24,
   parameter int unsigned hoffset      = 0
) (
   input  logic                            wrCLK,
   input  logic                            wrRST,
   input  logic                            vsync_i,
   input  logic                            hsync_i,
   input  logic                            vdata_valid_i,
   input  logic [data_width-1:0]           vdata_i,
   output logic                            wren,
   output logic [$clog2(num_of_pages)-1:0] wrpage,
   output logic [$clog2(pagesize)-1:0]     wraddr,
   output logic [data_width-1:0]           wrdata,
   output logic                            line_done,
   output logic [$clog2(num_of_pages)-1:0] line_page,
   output logic [$clog2(pagesize):0]       line_len,
   output logic                            line_ovf,
   output logic                            frame_start
);

   localparam int unsigned PW = $clog2(num_of_pages);
   localparam int unsigned AW = $clog2(pagesize);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} state_t;

   state_t                state_q, state_d;
   logic                  hsync_r_q, hsync_r_d;
   logic                  vsync_r_q, vsync_r_d;
   logic [PW-1:0]         page_q, page_d;
   logic [LW-1:0]         pix_cnt_q, pix_cnt_d;
   logic [AW-1:0]         skip_cnt_q, skip_cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  wren_q, wren_d;
   logic [PW-1:0]         wrpage_q, wrpage_d;
   logic [AW-1:0]         wraddr_q, wraddr_d;
   logic [data_width-1:0] wrdata_q, wrdata_d;
   logic                  line_done_q, line_done_d;
   logic [PW-1:0]         line_page_q, line_page_d;
   logic [LW-1:0]         line_len_q, line_len_d;
   logic                  line_ovf_q, line_ovf_d;
   logic                  frame_start_q, frame_start_d;

   logic                  hs_edge, vs_edge;
   logic [PW-1:0]         page_adv;

   assign hs_edge  = hsync_i & ~hsync_r_q;
   assign vs_edge  = vsync_i & ~vsync_r_q;
   assign page_adv = (page_q == PW'(num_of_pages - 1)) ? '0 : page_q + PW'(1);

   // State and datapath registers
   always_ff @(posedge wrCLK) begin
      if (wrRST) begin
         state_q       <= ST_IDLE;
         hsync_r_q     <= 1'b0;
         vsync_r_q     <= 1'b0;
         page_q        <= '0;
         pix_cnt_q     <= '0;
         skip_cnt_q    <= '0;
         ovf_q         <= 1'b0;
         wren_q        <= 1'b0;
         wrpage_q      <= '0;
         wraddr_q      <= '0;
         wrdata_q      <= '0;
         line_done_q   <= 1'b0;
         line_page_q   <= '0;
         line_len_q    <= '0;
         line_ovf_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hsync_r_q     <= hsync_r_d;
         vsync_r_q     <= vsync_r_d;
         page_q        <= page_d;
         pix_cnt_q     <= pix_cnt_d;
         skip_cnt_q    <= skip_cnt_d;
         ovf_q         <= ovf_d;
         wren_q        <= wren_d;
         wrpage_q      <= wrpage_d;
         wraddr_q      <= wraddr_d;
         wrdata_q      <= wrdata_d;
         line_done_q   <= line_done_d;
         line_page_q   <= line_page_d;
         line_len_q    <= line_len_d;
         line_ovf_q    <= line_ovf_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Next state: vsync always returns to waiting for the first line of the frame
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (vs_edge) state_d = ST_WAIT;
         ST_WAIT:   if (vs_edge) state_d = ST_WAIT;
                    else if (hs_edge) state_d = ST_ACTIVE;
         ST_ACTIVE: if (vs_edge) state_d = ST_WAIT;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Capture datapath and registered outputs
   always_comb begin
      hsync_r_d     = hsync_i;
      vsync_r_d     = vsync_i;
      page_d        = page_q;
      pix_cnt_d     = pix_cnt_q;
      skip_cnt_d    = skip_cnt_q;
      ovf_d         = ovf_q;
      wren_d        = 1'b0;
      wrpage_d      = wrpage_q;
      wraddr_d      = wraddr_q;
      wrdata_d      = wrdata_q;
      line_done_d   = 1'b0;
      line_page_d   = line_page_q;
      line_len_d    = line_len_q;
      line_ovf_d    = line_ovf_q;
      frame_start_d = 1'b0;

      // Empty lines are closed silently and do not consume a page
      if ((state_q == ST_ACTIVE) && (vs_edge || hs_edge) && (pix_cnt_q != '0)) begin
         line_done_d = 1'b1;
         line_page_d = page_q;
         line_len_d  = pix_cnt_q;
         line_ovf_d  = ovf_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (vs_edge) begin
               page_d        = '0;
               frame_start_d = 1'b1;
            end
         end
         ST_WAIT, ST_ACTIVE: begin
            if (vs_edge) begin
               page_d        = '0;
               frame_start_d = 1'b1;
               pix_cnt_d     = '0;
               skip_cnt_d    = '0;
               ovf_d         = 1'b0;
            end else if (hs_edge) begin
               if ((state_q == ST_ACTIVE) && (pix_cnt_q != '0)) page_d = page_adv;
               pix_cnt_d  = '0;
               skip_cnt_d = '0;
               ovf_d      = 1'b0;
            end else if ((state_q == ST_ACTIVE) && vdata_valid_i) begin
               if (skip_cnt_q < AW'(hoffset)) begin
                  skip_cnt_d = skip_cnt_q + AW'(1);
               end else if (pix_cnt_q < LW'(pagesize)) begin
                  wren_d    = 1'b1;
                  wrpage_d  = page_q;
                  wraddr_d  = AW'(pix_cnt_q);
                  wrdata_d  = vdata_i;
                  pix_cnt_d = pix_cnt_q + LW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign wren        = wren_q;
   assign wrpage      = wrpage_q;
   assign wraddr      = wraddr_q;
   assign wrdata      = wrdata_q;
   assign line_done   = line_done_q;
   assign line_page   = line_page_q;
   assign line_len    = line_len_q;
   assign line_ovf    = line_ovf_q;
   assign frame_start = frame_start_q;

endmodule
